aes128_cipher_iter: RTL

- Iterative AES-128 encryption core, one round per clock.
- Sits directly downstream of the combinational AES-128 key-expansion stage and consumes its 1408-bit expanded-key bus (11 round keys).
- Accepts one plaintext block through a valid/ready handshake.
- Returns the ciphertext through a valid/ready handshake 10 cycles after acceptance.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes128_cipher_iter_if.sv | 37 +++
 rtl/aes_round.sv | 63 ++++++
 rtl/aes128_cipher_iter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg - shared AES-128 constants and byte-level helper functions.
//
// Used by the iterative cipher core, its round sub-module and the upstream
// key-expansion stage, so that every S-box in the codebase comes from the
// same function.
//
// Contents:
//   NB, NK, NR, BLOCK_W, KEY_W   : AES-128 geometry
//   xtime(b)                     : multiply by x in GF(2^8), poly 0x11B
//   gf_mul(a, b)                 : general GF(2^8) multiply
//   gf_inv(a)                    : multiplicative inverse (a^254, 0 -> 0)
//   sbox(b)                      : forward S-box (inverse + affine map)
//   rk(exp_key, r)               : round key r from the expanded-key bus
package aes_pkg;

    localparam int NB      = 4;
    localparam int NK      = 4;
    localparam int NR      = 10;
    localparam int BLOCK_W = 128;
    localparam int KEY_W   = BLOCK_W * (NR + 1);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        // 0x1B is the low byte of the reduction polynomial 0x11B
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 == a^-1 for a != 0; the exponent is 0b11111110, so square once
    // and then accumulate the seven following powers. 0 maps to 0 as AES needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] p;
        res = 8'h01;
        p   = gf_mul(a, a);
        for (int i = 0; i < 7; i++) begin
            res = gf_mul(res, p);
            p   = gf_mul(p, p);
        end
        return res;
    endfunction

    // Computed rather than tabled so there is no 256-entry constant to mistype.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

    // Round key 0 sits at the MSBs of the expanded-key bus.
    function automatic logic [BLOCK_W-1:0] rk(input logic [KEY_W-1:0] exp_key,
                                              input logic [3:0]       r);
        int ri;
        ri = int'(r);
        return exp_key[KEY_W-1-BLOCK_W*ri -: BLOCK_W];
    endfunction

endpackage

// File: rtl/aes128_cipher_iter_if.sv
// aes128_cipher_iter_if - plaintext-in / ciphertext-out bus of the iterative
// AES-128 core.
//
// Signals:
//   in_valid, in_ready   : input handshake for one plaintext block
//   plaintext [127:0]    : block, byte 0 at [127:120], column-major
//   exp_key   [1407:0]   : expanded key, round key 0 at the MSBs
//   out_valid, out_ready : output handshake for one ciphertext block
//   ciphertext [127:0]   : result block, same byte order as plaintext
//   busy                 : core is processing or holding a result
//
// Modports:
//   master : block producer / result consumer
//   slave  : the cipher core
interface aes128_cipher_iter_if;
    import aes_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] plaintext;
    logic [KEY_W-1:0]   exp_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] ciphertext;
    logic               busy;

    modport master (
        output in_valid, plaintext, exp_key, out_ready,
        input  in_ready, out_valid, ciphertext, busy
    );

    modport slave (
        input  in_valid, plaintext, exp_key, out_ready,
        output in_ready, out_valid, ciphertext, busy
    );

endinterface

// File: rtl/aes_round.sv
// aes_round - one combinational AES encryption round.
//
// Ports:
//   state_in  [127:0] : current state, byte k at [127-8k -: 8]
//   round_key [127:0] : round key added at the end of the round
//   is_final          : 1 skips MixColumns (tenth round)
//   state_out [127:0] : AddRoundKey(MixColumns?(ShiftRows(SubBytes(state_in))))
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_in,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               is_final,
    output logic [BLOCK_W-1:0] state_out
);

    // Byte k of the state is row k%4, column k/4.
    logic [7:0]         sub_s [16];
    logic [7:0]         shf_s [16];
    logic [7:0]         mix_s [16];
    logic [BLOCK_W-1:0] pre_key_s;

    // SubBytes on all sixteen bytes
    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sub_s[k] = sbox(state_in[BLOCK_W-1-8*k -: 8]);
        end
    end

    // ShiftRows: row r takes its byte from column (c + r) mod 4
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shf_s[4*c+r] = sub_s[4*((c+r)%4)+r];
            end
        end
    end

    // MixColumns: each column multiplied by the circulant {02,03,01,01}
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mix_s[4*c+0] = xtime(shf_s[4*c+0]) ^ xtime(shf_s[4*c+1]) ^ shf_s[4*c+1]
                         ^ shf_s[4*c+2] ^ shf_s[4*c+3];
            mix_s[4*c+1] = shf_s[4*c+0] ^ xtime(shf_s[4*c+1]) ^ xtime(shf_s[4*c+2])
                         ^ shf_s[4*c+2] ^ shf_s[4*c+3];
            mix_s[4*c+2] = shf_s[4*c+0] ^ shf_s[4*c+1] ^ xtime(shf_s[4*c+2])
                         ^ xtime(shf_s[4*c+3]) ^ shf_s[4*c+3];
            mix_s[4*c+3] = xtime(shf_s[4*c+0]) ^ shf_s[4*c+0] ^ shf_s[4*c+1]
                         ^ shf_s[4*c+2] ^ xtime(shf_s[4*c+3]);
        end
    end

    // Repack into the bus order, skipping MixColumns on the final round
    always_comb begin
        pre_key_s = '0;
        for (int k = 0; k < 16; k++) begin
            pre_key_s[BLOCK_W-1-8*k -: 8] = is_final ? shf_s[k] : mix_s[k];
        end
    end

    assign state_out = pre_key_s ^ round_key;

endmodule

// File: rtl/aes128_cipher_iter.sv
// aes128_cipher_iter - iterative AES-128 encryption core, one round per clock.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : aes128_cipher_iter_if.slave (in/out handshakes, plaintext,
//          expanded key, ciphertext, busy)
//
// Flow: IDLE accepts a block and applies round key 0; ROUND runs rounds
// 1..10 (MixColumns skipped in round 10) through a single aes_round
// instance; DONE holds the ciphertext until the consumer takes it.
// The acceptance edge is cycle 0 and out_valid is high after edge 10.
//
// Build option AES_KEY_LATCH_EN: when defined, the expanded key is
// captured on the acceptance edge and rounds 1..10 read the captured copy,
// so upstream may change exp_key immediately. When undefined, round keys
// come straight from the exp_key port, which must then stay stable until
// DONE.
module aes128_cipher_iter
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    aes128_cipher_iter_if.slave  bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ROUND = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [3:0]         rnd_r;
    logic [BLOCK_W-1:0] blk_r;
    logic [BLOCK_W-1:0] ct_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               accept_s;
    logic               last_s;
    logic [KEY_W-1:0]   key_src_s;
    logic [BLOCK_W-1:0] rk0_s;
    logic [BLOCK_W-1:0] rkr_s;
    logic [BLOCK_W-1:0] round_out_s;

    assign accept_s = (state_r == ST_IDLE) && bus.in_valid;
    assign last_s   = (rnd_r == 4'(NR));

`ifdef AES_KEY_LATCH_EN
    logic [KEY_W-1:0] key_r;

    // Capture the whole expanded key on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_r <= '0;
        end else if (accept_s) begin
            key_r <= bus.exp_key;
        end else begin
            key_r <= key_r;
        end
    end

    assign key_src_s = key_r;
`else
    assign key_src_s = bus.exp_key;
`endif

    // Round key 0 is only needed on the acceptance edge, so it always comes
    // from the live bus; the captured copy is not yet loaded at that point.
    assign rk0_s = rk(bus.exp_key, 4'd0);
    assign rkr_s = rk(key_src_s, rnd_r);

    aes_round u_round (
        .state_in  (blk_r),
        .round_key (rkr_s),
        .is_final  (last_s),
        .state_out (round_out_s)
    );

    // Next-state decode for the IDLE / ROUND / DONE sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and handshake outputs, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_ROUND) || (state_nxt_s == ST_DONE);
        end
    end

    // Datapath: round state, round counter and ciphertext holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_r <= '0;
            rnd_r <= 4'd0;
            ct_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        blk_r <= bus.plaintext ^ rk0_s;
                        rnd_r <= 4'd1;
                    end else begin
                        blk_r <= blk_r;
                        rnd_r <= rnd_r;
                    end
                    ct_r <= ct_r;
                end
                ST_ROUND: begin
                    blk_r <= round_out_s;
                    if (last_s) begin
                        ct_r  <= round_out_s;
                        rnd_r <= 4'd0;
                    end else begin
                        ct_r  <= ct_r;
                        rnd_r <= rnd_r + 4'd1;
                    end
                end
                default: begin
                    blk_r <= blk_r;
                    rnd_r <= rnd_r;
                    ct_r  <= ct_r;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.busy       = busy_r;
    assign bus.ciphertext = ct_r;

endmodule
